// File: rtl/ram_pkg.sv
// Shared types and helpers for the RAM block and its UART command front end.
// Receiver/parser state encodings, opcode layout and baud divider math.
package ram_pkg;

  localparam int OP_WE_BIT = 7;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HI
  } rx_state_e;

  typedef enum logic [1:0] {
    P_OPC,
    P_DAT,
    P_HOLD
  } cmd_state_e;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Opcode bits between the address field and the write flag.
  function automatic logic [7:0] rsvd_mask(input int aw);
    logic [7:0] m;
    m = 8'h7f;
    for (int i = 0; i < 8; i++) begin
      if (i < aw) m[i] = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, bit FSM and baud counter.
// Emits a one-cycle byte_vld with the byte, or a frame_err pulse.
module uart_rx_byte
  import ram_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_vld,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [1:0]    sync;
  logic          rxs;
  rx_state_e     st, st_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bitn, bit_d;
  logic [7:0]    sh, sh_d;
  logic          vld_d, ferr_d;

  assign rxs = sync[1];
  assign byte_data = sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 2'b11;
      st        <= RX_IDLE;
      cnt       <= '0;
      bitn      <= '0;
      sh        <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      st        <= st_d;
      cnt       <= cnt_d;
      bitn      <= bit_d;
      sh        <= sh_d;
      byte_vld  <= vld_d;
      frame_err <= ferr_d;
    end
  end

  always_comb begin
    st_d   = st;
    cnt_d  = cnt + 1'b1;
    bit_d  = bitn;
    sh_d   = sh;
    vld_d  = 1'b0;
    ferr_d = 1'b0;
    unique case (st)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rxs) st_d = RX_START;
      end
      RX_START: begin
        if (cnt == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == LAST) begin
          cnt_d = '0;
          sh_d  = {rxs, sh[7:1]};
          bit_d = bitn + 1'b1;
          if (bitn == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == LAST) begin
          cnt_d = '0;
          if (rxs) begin
            vld_d = 1'b1;
            st_d  = RX_IDLE;
          end else begin
            ferr_d = 1'b1;
            st_d   = RX_WAIT_HI;
          end
        end
      end
      RX_WAIT_HI: begin
        cnt_d = '0;
        if (rxs) st_d = RX_IDLE;
      end
      default: st_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/ram_cmd_rx.sv
// UART command receiver: parses opcode/data bytes into RAM requests.
// Presents one read or write at a time on a valid/ready port.
module ram_cmd_rx
  import ram_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              req_valid,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [7:0]        req_data,
  input  logic              req_ready,
  output logic              frame_err,
  output logic              cmd_err,
  output logic              overrun
);

  localparam logic [7:0] RSVD = rsvd_mask(ADDR_W);

  logic        byte_vld;
  logic [7:0]  byte_data;
  cmd_state_e  ps, ps_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        data_d;
  logic        cerr_d, ovr_d;
  logic        xfer, take_opc;

  uart_rx_byte #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .byte_vld (byte_vld),
    .byte_data(byte_data),
    .frame_err(frame_err)
  );

  assign req_valid = (ps == P_HOLD);
  assign xfer      = req_valid && req_ready;
  // A byte landing in the transfer cycle starts the next command.
  assign take_opc  = byte_vld && ((ps == P_OPC) || xfer);

  always_ff @(posedge clk) begin
    if (rst) begin
      ps       <= P_OPC;
      req_we   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
      cmd_err  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      ps       <= ps_d;
      req_we   <= we_d;
      req_addr <= addr_d;
      req_data <= data_d;
      cmd_err  <= cerr_d;
      overrun  <= ovr_d;
    end
  end

  always_comb begin
    ps_d   = ps;
    we_d   = req_we;
    addr_d = req_addr;
    data_d = req_data;
    cerr_d = 1'b0;
    ovr_d  = 1'b0;
    if (xfer) ps_d = P_OPC;
    if (req_valid && !req_ready && byte_vld) ovr_d = 1'b1;
    if (ps == P_DAT) begin
      if (frame_err) begin
        ps_d = P_OPC;
      end else if (byte_vld) begin
        data_d = byte_data;
        ps_d   = P_HOLD;
      end
    end
    if (take_opc) begin
      if (|(byte_data & RSVD)) begin
        cerr_d = 1'b1;
      end else begin
        we_d   = byte_data[OP_WE_BIT];
        addr_d = byte_data[ADDR_W-1:0];
        data_d = '0;
        ps_d   = byte_data[OP_WE_BIT] ? P_DAT : P_HOLD;
      end
    end
  end

endmodule

// File: tb/tb_ram_cmd_rx.sv
// Bench for ram_cmd_rx: directed scenarios plus randomized command
// streams checked against a byte-level command model.
module tb_ram_cmd_rx;

  localparam int CLK_HZ = 16;
  localparam int BAUD   = 1;
  localparam int AW     = 4;
  localparam int DIV    = 16;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } req_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx = 1'b1;
  logic          req_ready = 1'b0;
  logic          req_valid, req_we;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_data;
  logic          frame_err, cmd_err, overrun;

  ram_cmd_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .ADDR_W(AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .req_valid(req_valid),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ready(req_ready),
    .frame_err(frame_err),
    .cmd_err  (cmd_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t_start = 0;
  bit rnd_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  req_t got[$];
  int n_ferr = 0, n_cerr = 0, n_ovr = 0;
  int t_rise = 0, t_ovr = 0, vrun = 0, last_run = 0;
  bit prev_v = 1'b0;

  always @(negedge clk) begin
    if (req_valid && !prev_v) t_rise = cyc;
    if (req_valid) vrun++;
    else if (prev_v) begin
      last_run = vrun;
      vrun = 0;
    end
    prev_v = req_valid;
    if (req_valid && req_ready) got.push_back({req_we, req_addr, req_data});
    if (frame_err) n_ferr++;
    if (cmd_err) n_cerr++;
    if (overrun) begin
      n_ovr++;
      t_ovr = cyc;
    end
  end

  // Expected request for a legal command, from the opcode layout.
  function automatic req_t model(input logic [7:0] opc, input logic [7:0] dat);
    req_t r;
    r.we   = opc[7];
    r.addr = opc[AW-1:0];
    r.data = opc[7] ? dat : 8'h00;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) req_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    rx = 1'b0;
    t_start = cyc;
    repeat (DIV) tick();
    for (int i = 0; i < nbits; i++) begin
      rx = b[i];
      repeat (DIV) tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bits(b, 8);
    rx = stop;
    repeat (DIV) tick();
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", req_valid); end
    n_cmp++; if (req_we !== 1'b0) begin n_bad++; $display("FAIL rst_we got %b want 0", req_we); end
    n_cmp++; if (req_addr !== '0) begin n_bad++; $display("FAIL rst_addr got %h want 0", req_addr); end
    n_cmp++; if (req_data !== 8'h00) begin n_bad++; $display("FAIL rst_data got %h want 00", req_data); end
    n_cmp++; if ({frame_err, cmd_err, overrun} !== 3'b000) begin n_bad++; $display("FAIL rst_pulses got %b want 000", {frame_err, cmd_err, overrun}); end
  endtask

  task automatic test_write();
    int g0 = got.size();
    int e0 = n_ferr + n_cerr + n_ovr;
    req_ready = 1'b1;
    send_byte(8'h85, 1'b1);
    send_byte(8'h3C, 1'b1);
    repeat (10) tick();
    n_cmp++; if (got.size() - g0 !== 1) begin n_bad++; $display("FAIL wr_count got %0d want 1", got.size() - g0); end
    n_cmp++; if (got[g0] !== model(8'h85, 8'h3C)) begin n_bad++; $display("FAIL wr_req got %h want %h", got[g0], model(8'h85, 8'h3C)); end
    n_cmp++; if (last_run !== 1) begin n_bad++; $display("FAIL wr_valid_len got %0d want 1", last_run); end
    n_cmp++; if (n_ferr + n_cerr + n_ovr - e0 !== 0) begin n_bad++; $display("FAIL wr_errs got %0d want 0", n_ferr + n_cerr + n_ovr - e0); end
  endtask

  task automatic test_read();
    int g0 = got.size();
    int lat;
    req_ready = 1'b1;
    send_byte(8'h0A, 1'b1);
    repeat (10) tick();
    lat = t_rise - t_start;
    n_cmp++; if (got.size() - g0 !== 1) begin n_bad++; $display("FAIL rd_count got %0d want 1", got.size() - g0); end
    n_cmp++; if (got[g0] !== model(8'h0A, 8'hFF)) begin n_bad++; $display("FAIL rd_req got %h want %h", got[g0], model(8'h0A, 8'hFF)); end
    n_cmp++; if (lat < 155 || lat > 157) begin n_bad++; $display("FAIL rd_latency got %0d want 155..157", lat); end
  endtask

  task automatic test_glitch();
    int g0 = got.size();
    int e0 = n_ferr + n_cerr + n_ovr;
    int c0;
    rx = 1'b0;
    repeat (5) tick();
    rx = 1'b1;
    repeat (200) tick();
    n_cmp++; if (got.size() - g0 !== 0) begin n_bad++; $display("FAIL glitch_req got %0d want 0", got.size() - g0); end
    n_cmp++; if (n_ferr + n_cerr + n_ovr - e0 !== 0) begin n_bad++; $display("FAIL glitch_pulses got %0d want 0", n_ferr + n_cerr + n_ovr - e0); end
    c0 = n_cerr;
    send_byte(8'h70, 1'b1);
    repeat (10) tick();
    n_cmp++; if (n_cerr - c0 !== 1) begin n_bad++; $display("FAIL rsvd_cmd_err got %0d want 1", n_cerr - c0); end
    n_cmp++; if (got.size() - g0 !== 0) begin n_bad++; $display("FAIL rsvd_req got %0d want 0", got.size() - g0); end
  endtask

  task automatic test_framing();
    int g0 = got.size();
    int f0 = n_ferr;
    send_byte(8'h85, 1'b1);
    send_byte(8'h11, 1'b0);
    repeat (20) tick();
    n_cmp++; if (n_ferr - f0 !== 1) begin n_bad++; $display("FAIL frame_err_cnt got %0d want 1", n_ferr - f0); end
    n_cmp++; if (got.size() - g0 !== 0) begin n_bad++; $display("FAIL frame_req got %0d want 0", got.size() - g0); end
    send_byte(8'h02, 1'b1);
    repeat (10) tick();
    n_cmp++; if (got.size() - g0 !== 1) begin n_bad++; $display("FAIL frame_recover_cnt got %0d want 1", got.size() - g0); end
    n_cmp++; if (got[g0] !== model(8'h02, 8'h00)) begin n_bad++; $display("FAIL frame_recover_req got %h want %h", got[g0], model(8'h02, 8'h00)); end
  endtask

  task automatic test_backpressure();
    int g0 = got.size();
    int o0 = n_ovr;
    int lat;
    req_ready = 1'b0;
    send_byte(8'h01, 1'b1);
    send_byte(8'h03, 1'b1);
    repeat (5) tick();
    lat = t_ovr - t_start;
    n_cmp++; if (n_ovr - o0 !== 1) begin n_bad++; $display("FAIL ovr_cnt got %0d want 1", n_ovr - o0); end
    n_cmp++; if (lat < 155 || lat > 157) begin n_bad++; $display("FAIL ovr_time got %0d want 155..157", lat); end
    n_cmp++; if (req_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid got %b want 1", req_valid); end
    n_cmp++; if (req_addr !== 4'h1) begin n_bad++; $display("FAIL bp_addr got %h want 1", req_addr); end
    req_ready = 1'b1;
    repeat (200) tick();
    n_cmp++; if (got.size() - g0 !== 1) begin n_bad++; $display("FAIL bp_xfer_cnt got %0d want 1", got.size() - g0); end
    n_cmp++; if (got[g0] !== model(8'h01, 8'h00)) begin n_bad++; $display("FAIL bp_req got %h want %h", got[g0], model(8'h01, 8'h00)); end
  endtask

  task automatic test_reset_mid();
    int g0;
    req_ready = 1'b1;
    send_byte(8'h85, 1'b1);
    send_bits(8'h85, 4);
    rst = 1'b1;
    rx = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if ({req_valid, req_we, req_addr, req_data} !== '0) begin n_bad++; $display("FAIL midrst_outs got %h want 0", {req_valid, req_we, req_addr, req_data}); end
    n_cmp++; if ({frame_err, cmd_err, overrun} !== 3'b000) begin n_bad++; $display("FAIL midrst_pulses got %b want 000", {frame_err, cmd_err, overrun}); end
    repeat (40) tick();
    g0 = got.size();
    send_byte(8'h04, 1'b1);
    repeat (10) tick();
    n_cmp++; if (got.size() - g0 !== 1) begin n_bad++; $display("FAIL midrst_cnt got %0d want 1", got.size() - g0); end
    n_cmp++; if (got[g0] !== model(8'h04, 8'h00)) begin n_bad++; $display("FAIL midrst_req got %h want %h", got[g0], model(8'h04, 8'h00)); end
  endtask

  task automatic test_back_to_back();
    req_t exp[$];
    int g0 = got.size();
    int c0 = n_cerr;
    int o0 = n_ovr;
    int nbad_op = 0;
    logic [7:0] opc, dat;
    rnd_rdy = 1'b1;
    for (int k = 0; k < 24; k++) begin
      opc = 8'($urandom_range(0, 255));
      dat = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) begin
        if (opc[6:4] == 3'b000) opc[4] = 1'b1;
        nbad_op++;
        send_byte(opc, 1'b1);
      end else begin
        opc[6:4] = 3'b000;
        exp.push_back(model(opc, dat));
        send_byte(opc, 1'b1);
        if (opc[7]) send_byte(dat, 1'b1);
      end
    end
    rnd_rdy = 1'b0;
    req_ready = 1'b1;
    repeat (20) tick();
    n_cmp++; if (got.size() - g0 !== exp.size()) begin n_bad++; $display("FAIL rnd_cnt got %0d want %0d", got.size() - g0, exp.size()); end
    foreach (exp[i]) begin
      n_cmp++; if (got[g0 + i] !== exp[i]) begin n_bad++; $display("FAIL rnd_req%0d got %h want %h", i, got[g0 + i], exp[i]); end
    end
    n_cmp++; if (n_cerr - c0 !== nbad_op) begin n_bad++; $display("FAIL rnd_cmd_err got %0d want %0d", n_cerr - c0, nbad_op); end
    n_cmp++; if (n_ovr - o0 !== 0) begin n_bad++; $display("FAIL rnd_ovr got %0d want 0", n_ovr - o0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_glitch();
    test_framing();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_cmd_rx.md
# ram_cmd_rx

UART command receiver that sits directly upstream of the RAM block and turns the serial `rx` line into single-word read/write requests. It contains an 8N1 receiver and a byte-level command parser. It presents each decoded command on a valid/ready request port that the RAM's storage and response logic consumes.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency.
- `BAUD`, 115200: line rate. `DIV = CLK_HZ/BAUD`, truncated; `DIV >= 8` is required.
- `ADDR_W`, 4: RAM address width, 1..7.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rx` in 1: asynchronous serial input; idles high.
- `req_valid` out 1: a request is pending.
- `req_we` out 1: 1 = write, 0 = read.
- `req_addr` out `ADDR_W`: word address.
- `req_data` out 8: write data; 0x00 for reads.
- `req_ready` in 1: the consumer accepts the request this cycle.
- `frame_err` out 1: one-cycle pulse; the stop bit sampled low.
- `cmd_err` out 1: one-cycle pulse; the opcode had nonzero reserved bits.
- `overrun` out 1: one-cycle pulse; a byte was dropped while a request was pending.

## Operation
- **Synchroniser:** `rx` passes through a 2-FF synchroniser; both flops reset to 1.
- **Bit receiver states:** IDLE, START, DATA, STOP, WAIT_HI.
  - IDLE → START when synced `rx` is 0. The baud counter clears.
  - START: sample at count `DIV/2-1`. A 1 means a glitch → IDLE, with no pulse. A 0 → DATA, counter cleared.
  - DATA: sample every `DIV` cycles, 8 bits, LSB first.
  - STOP: sample after `DIV` cycles.
    - 1 → pulse the internal `byte_vld` with the shifted byte, then → IDLE.
    - 0 → pulse `frame_err`, discard the byte, then → WAIT_HI.
  - WAIT_HI → IDLE when synced `rx` is 1.
- **Opcode byte:** bit7 = write, bits[ADDR_W-1:0] = address, bits[6:ADDR_W] are reserved and must be 0.
- **Parser states:** OPC, DAT, HOLD.
  - OPC, on `byte_vld`:
    - Reserved bits nonzero → pulse `cmd_err`, stay in OPC.
    - Read → load `req_*` and go to HOLD.
    - Write → latch the address and go to DAT.
  - DAT, on `byte_vld` → load `req_data` and go to HOLD.
  - HOLD: `req_valid` is 1; `req_*` are stable.
    - A cycle with `req_valid && req_ready` is the transfer → OPC.
    - `byte_vld` in HOLD without a same-cycle transfer → byte dropped, `overrun` pulses.
    - `byte_vld` in the same cycle as the transfer is processed as an opcode.
- **`frame_err` in DAT:** discards the partial write; the parser → OPC.
- **Reset values:**
  - All outputs 0. Receiver in IDLE, parser in OPC, counters 0.
  - Reset mid-frame or mid-command discards all partial state.

## Timing
- **Start edge to `byte_vld`:** a falling edge of `rx` at cycle 0 gives `byte_vld` at cycle `2 + DIV/2 + 9*DIV`, ±1 cycle.
- **Request latency:** `req_valid` rises 1 cycle after the `byte_vld` of the final byte of the command: the opcode for a read, the data byte for a write.
- **Handshake:**
  - `req_valid` falls in the cycle after the transfer.
  - `req_ready` may be high before `req_valid`; the transfer then occurs in the first valid cycle.
  - Back-to-back requests have no bubble beyond the byte time.
- **Error pulses:** all pulses are exactly 1 cycle wide, registered.

## Structure
- **Package `ram_pkg`:**
  - receiver and parser state enums;
  - `OP_WE_BIT = 7`;
  - the `DIV` computation function.
  - The RAM block imports the same package.
- **Sub-module `uart_rx_byte`:**
  - contains the synchroniser, bit FSM and baud counter;
  - outputs `byte_vld`, `byte`, `frame_err`.
- **Parser:** lives in `ram_cmd_rx` itself.

## Test plan
Bench uses `CLK_HZ=16`, `BAUD=1` (`DIV=16`) and `ADDR_W=4`.
- **Write:** send 0x85 then 0x3C with `req_ready=1` → exactly one request: `we=1`, `addr=5`, `data=0x3C`, valid for 1 cycle; no error pulses.
- **Read:** send 0x0A → `req_valid` with `we=0`, `addr=0xA`, `data=0x00`, 1 cycle after opcode `byte_vld`.
- **Glitch and reserved bits:**
  - `rx` low for 5 cycles, then high → no byte, no pulses.
  - Send 0x70 → `cmd_err` pulse, no request.
- **Framing:**
  - Send 0x85, then a byte 0x11 with stop bit 0 → `frame_err` pulse, no request.
  - `rx` high, then send 0x02 → read request at `addr=2`.
- **Backpressure:**
  - `req_ready=0`, send 0x01 then 0x03 → `overrun` pulse at the second `byte_vld`; `req_addr` stays 1.
  - Raise `req_ready` → one transfer, `addr=1`, no further request.
- **Reset:**
  - Assert `rst` for 1 cycle after 4 data bits of 0x85 → all outputs 0.
  - Full 0x04 frame after reset → read request at `addr=4`.
